osd_field_sequencer: RTL and testbench

//  Upstream driver for the OSD unsigned-decimal writer. Walks a table of NUM_FIELDS

---
 rtl/osd_field_sequencer_if.sv | 14 +
 rtl/osd_field_sequencer.sv | 139 +++++++++++++
 tb/tb_osd_field_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/osd_field_sequencer_if.sv
// osd_field_sequencer_if: job handshake between the field sequencer and the OSD decimal writer.
interface osd_field_sequencer_if #(parameter int WIDTH = 32);
  logic             wr_start;
  logic [15:0]      wr_base_addr;
  logic [7:0]       wr_min_width;
  logic             wr_zero_pad;
  logic [WIDTH-1:0] wr_value;
  logic             wr_busy;
  logic             wr_done;
  modport master (output wr_start, wr_base_addr, wr_min_width, wr_zero_pad, wr_value,
                  input wr_busy, wr_done);
  modport slave (input wr_start, wr_base_addr, wr_min_width, wr_zero_pad, wr_value,
                 output wr_busy, wr_done);
endinterface

// File: rtl/osd_field_sequencer.sv
// osd_field_sequencer: walks the numeric field table, issuing one writer job per enabled slot.
// Define OSD_SEQ_CHANGE_SKIP_EN to skip slots whose value equals the last completed write.
module osd_field_sequencer #(
  parameter int NUM_FIELDS = 8,
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        trigger_i,
  input  logic                        err_clr_i,
  input  logic [NUM_FIELDS-1:0]       fld_en_i,
  input  logic [NUM_FIELDS*16-1:0]    fld_addr_i,
  input  logic [NUM_FIELDS*8-1:0]     fld_width_i,
  input  logic [NUM_FIELDS-1:0]       fld_zpad_i,
  input  logic [NUM_FIELDS*WIDTH-1:0] fld_value_i,
  osd_field_sequencer_if.master       wr,
  output logic                        busy_o,
  output logic                        pass_done_o,
  output logic                        err_timeout_o
);
  localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pending_q, pending_d, busy_q, busy_d, pd_q, pd_d;
  logic             start_q, start_d, err_q, err_d, zpad_q, zpad_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       width_q, width_d;
  logic [WIDTH-1:0] value_q, value_d, cur_value;
  logic             skip, timeout_hit, last;
  assign cur_value   = fld_value_i[WIDTH*idx_q +: WIDTH];
  assign timeout_hit = state_q == S_WAIT && !wr.wr_done && cnt_q == CW'(TIMEOUT-1);
  assign last        = idx_q == IW'(NUM_FIELDS-1);
`ifdef OSD_SEQ_CHANGE_SKIP_EN
  logic [WIDTH-1:0]      shadow_q [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] valid_q;
  assign skip = valid_q[idx_q] && cur_value == shadow_q[idx_q];
  // Only a completed write makes the shadow trustworthy; a timeout forces a rewrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) shadow_q[i] <= '0;
    end else begin
      if (err_clr_i) valid_q <= '0;
      if (state_q == S_WAIT && wr.wr_done) begin
        valid_q[idx_q]  <= 1'b1;
        shadow_q[idx_q] <= value_q;
      end else if (timeout_hit) valid_q[idx_q] <= 1'b0;
    end
  end
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q || (trigger_i && state_q != S_IDLE);
    start_d   = 1'b0;
    err_d     = (err_q && !err_clr_i) || timeout_hit;
    addr_d    = addr_q;
    width_d   = width_q;
    zpad_d    = zpad_q;
    value_d   = value_q;
    case (state_q)
      S_IDLE: if (trigger_i) begin
        state_d = S_SELECT;
        idx_d   = '0;
      end
      S_SELECT: if (fld_en_i[idx_q] && !skip) begin
        state_d = S_ISSUE;
        addr_d  = fld_addr_i[16*idx_q +: 16];
        width_d = fld_width_i[8*idx_q +: 8];
        zpad_d  = fld_zpad_i[idx_q];
        value_d = cur_value;
      end else state_d = S_NEXT;
      S_ISSUE: if (!wr.wr_busy) begin
        state_d = S_WAIT;
        start_d = 1'b1;
        cnt_d   = '0;
      end
      S_WAIT: if (wr.wr_done || timeout_hit) state_d = S_NEXT;
              else cnt_d = cnt_q + 1'b1;
      S_NEXT: if (last) state_d = S_DONE;
              else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_SELECT;
              end
      S_DONE: if (pending_d) begin
        pending_d = 1'b0;
        idx_d     = '0;
        state_d   = S_SELECT;
      end else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
    pd_d   = state_d == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      pd_q      <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      width_q   <= '0;
      zpad_q    <= 1'b0;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      pd_q      <= pd_d;
      start_q   <= start_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      width_q   <= width_d;
      zpad_q    <= zpad_d;
      value_q   <= value_d;
    end
  end
  assign wr.wr_start     = start_q;
  assign wr.wr_base_addr = addr_q;
  assign wr.wr_min_width = width_q;
  assign wr.wr_zero_pad  = zpad_q;
  assign wr.wr_value     = value_q;
  assign busy_o          = busy_q;
  assign pass_done_o     = pd_q;
  assign err_timeout_o   = err_q;
endmodule

// File: tb/tb_osd_field_sequencer.sv
// tb_osd_field_sequencer: randomized scoreboard bench with a pass-level model of the field table.
module tb_osd_field_sequencer;
  localparam int N = 4, W = 32, TO = 64;
`ifdef OSD_SEQ_CHANGE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 0, rst_n = 0, trigger = 0, err_clr = 0;
  logic [N-1:0] en = '0, zpad = '0;
  logic [N*16-1:0] addr = '0;
  logic [N*8-1:0] width = '0;
  logic [N*W-1:0] value = '0;
  logic busy, pass_done, err_timeout;
  osd_field_sequencer_if #(.WIDTH(W)) wr_if();
  osd_field_sequencer #(.NUM_FIELDS(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .trigger_i(trigger), .err_clr_i(err_clr),
    .fld_en_i(en), .fld_addr_i(addr), .fld_width_i(width), .fld_zpad_i(zpad),
    .fld_value_i(value), .wr(wr_if), .busy_o(busy), .pass_done_o(pass_done),
    .err_timeout_o(err_timeout));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  typedef struct {bit is_pass; logic [63:0] f;} exp_t;
  exp_t q[$];
  logic [N-1:0] mvalid = '0;
  logic [W-1:0] mshadow [N];
  int lat = 12, w_left = 0, w_tail = 0;
  bit hang = 0;
  logic m_pb = 0, m_act = 0;
  logic [63:0] m_held = '0, m_cur;
  exp_t m_e;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] pack(logic [15:0] a, logic [7:0] w, logic z, logic [W-1:0] v);
    return {7'd0, a, w, z, v};
  endfunction
  // One pass = every enabled slot in index order (unchanged slots dropped when skipping), then pass_done.
  task automatic push_pass();
    for (int i = 0; i < N; i++)
      if (en[i] && !(SKIP && mvalid[i] && mshadow[i] == value[W*i +: W])) begin
        q.push_back('{1'b0, pack(addr[16*i +: 16], width[8*i +: 8], zpad[i], value[W*i +: W])});
        mvalid[i]  = !hang;
        mshadow[i] = value[W*i +: W];
      end
    q.push_back('{1'b1, 64'd0});
  endtask
  task automatic pulse();
    trigger = 1;
    @(negedge clk);
    trigger = 0;
  endtask
  task automatic clr_err();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    mvalid = '0;
  endtask
  task automatic wait_idle(output int pd);
    bit seen = 0, fin = 0;
    pd = 0;
    for (int c = 0; c < 5000 && !fin; c++) begin
      @(negedge clk);
      if (pass_done) pd++;
      if (busy) seen = 1;
      else if (seen) fin = 1;
    end
    chk("pass_end_in_budget", fin, 1);
  endtask
  task automatic run(input int extra);
    int pd;
    push_pass();
    if (extra > 0) push_pass();
    pulse();
    for (int i = 0; i < extra; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      pulse();
    end
    wait_idle(pd);
    chk("pass_done_count", pd, extra > 0 ? 2 : 1);
  endtask
  task automatic rand_desc();
    en = N'($urandom);
    zpad = N'($urandom);
    for (int i = 0; i < N; i++) begin
      addr[16*i +: 16] = 16'($urandom);
      width[8*i +: 8] = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) value[W*i +: W] = $urandom;
    end
  endtask
  // Writer model: done `lat` cycles after start, optional busy tail; in hang mode it never answers.
  initial begin
    wr_if.wr_busy = 0;
    wr_if.wr_done = 0;
    forever begin
      @(posedge clk);
      #1;
      wr_if.wr_done = 0;
      if (!rst_n) begin
        w_left = 0; w_tail = 0; wr_if.wr_busy = 0;
      end else if (wr_if.wr_start) begin
        w_left = lat; w_tail = 0; wr_if.wr_busy = !hang;
      end else if (w_left > 0) begin
        w_left--;
        if (w_left == 0 && !hang) begin
          wr_if.wr_done = 1;
          w_tail = $urandom_range(0, 3);
          if (w_tail == 0) wr_if.wr_busy = 0;
        end
      end else if (w_tail > 0) begin
        w_tail--;
        if (w_tail == 0) wr_if.wr_busy = 0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      m_cur = pack(wr_if.wr_base_addr, wr_if.wr_min_width, wr_if.wr_zero_pad, wr_if.wr_value);
      if (!rst_n) begin
        m_act = 0; m_pb = 0;
      end else begin
        if (wr_if.wr_start) begin
          chk("start_while_wr_busy", m_pb, 0);
          chk("start_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            m_e = q.pop_front();
            chk("job_kind", m_e.is_pass, 0);
            chk("job_fields", m_cur, m_e.f);
          end
          m_held = m_cur; m_act = 1;
        end else if (m_act) chk("job_hold", m_cur, m_held);
        if (wr_if.wr_done || !wr_if.wr_busy) m_act = 0;
        if (pass_done) begin
          chk("pass_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            m_e = q.pop_front();
            chk("pass_kind", m_e.is_pass, 1);
          end
        end
        m_pb = wr_if.wr_busy;
      end
    end
  end
  initial begin
    int n, c, starts;
    bit got;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_ctrl", {busy, pass_done, err_timeout, wr_if.wr_start}, 0);
    chk("reset_fields", pack(wr_if.wr_base_addr, wr_if.wr_min_width, wr_if.wr_zero_pad, wr_if.wr_value), 0);
    // all slots enabled, fixed latency
    en = 4'b1111;
    for (int i = 0; i < N; i++) begin
      addr[16*i +: 16] = 16'h100 * 16'(i + 1); width[8*i +: 8] = 8'(i + 2); value[W*i +: W] = 1000 * (i + 1);
    end
    zpad = 4'b1010;
    run(0);
    chk("idle_after_pass", busy, 0);
    en = 4'b0101;
    run(0);
    // all disabled: busy cycles through pass_done inclusive
    en = 4'b0000;
    push_pass();
    pulse();
    n = 0; c = 0; got = 0;
    while (!got && c < 50) begin
      if (busy) n++;
      if (pass_done) got = 1;
      else begin @(negedge clk); c++; end
    end
    chk("alldis_pass_done", got, 1);
    chk("alldis_cycles", n, 2*N+1);
    @(negedge clk);
    chk("alldis_idle", busy, 0);
    // writer never answers
    hang = 1; en = 4'b1111;
    push_pass();
    pulse();
    c = 0;
    while (!wr_if.wr_start && c < 20) begin @(negedge clk); c++; end
    repeat (60) @(negedge clk);
    chk("err_before_timeout", err_timeout, 0);
    repeat (10) @(negedge clk);
    chk("err_after_timeout", err_timeout, 1);
    wait_idle(n);
    chk("timeout_pass_done", n, 1);
    chk("err_sticky", err_timeout, 1);
    hang = 0;
    clr_err();
    chk("err_cleared", err_timeout, 0);
    run(3);
    // reset while waiting on slot 2
    lat = 40; en = 4'b1111;
    push_pass();
    pulse();
    starts = 0; c = 0;
    while (starts < 3 && c < 300) begin
      @(negedge clk); c++;
      if (wr_if.wr_start) starts++;
    end
    chk("reached_slot2", starts, 3);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_reset_ctrl", {busy, pass_done, err_timeout, wr_if.wr_start}, 0);
    chk("async_reset_fields", pack(wr_if.wr_base_addr, wr_if.wr_min_width, wr_if.wr_zero_pad, wr_if.wr_value), 0);
    q.delete();
    mvalid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    lat = 12;
    run(0);
    // change detection: full redraw, then only slot 1 changes
    clr_err();
    for (int i = 0; i < N; i++) value[W*i +: W] = $urandom;
    run(0);
    value[W*1 +: W] = ~value[W*1 +: W];
    run(0);
    for (int r = 0; r < 10; r++) begin
      rand_desc();
      lat = $urandom_range(1, 15);
      run($urandom_range(0, 3));
    end
    chk("queue_drained", q.size(), 0);
    chk("final_err", err_timeout, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
